// File: rtl/smc_pwm_core_if.sv
// rtl/smc_pwm_core_if.sv - Q-bus register slave interface
interface smc_pwm_core_if;
  logic        QSEL;
  logic        QWRITE;
  logic [6:0]  QADDR;
  logic [15:0] QDATAIN;
  logic [15:0] QDATAOUT;

  modport master (
    output QSEL, QWRITE, QADDR, QDATAIN,
    input  QDATAOUT
  );

  modport slave (
    input  QSEL, QWRITE, QADDR, QDATAIN,
    output QDATAOUT
  );
endinterface

// File: rtl/smc_pwm_core.sv
// rtl/smc_pwm_core.sv - sign-magnitude PWM engine with Q-bus register slave
module smc_pwm_core #(
  parameter int N_CH  = 12,
  parameter int PER_W = 11
) (
  input  logic            QCLK,
  input  logic            QRESET,
  smc_pwm_core_if.slave   qbus,
  output logic [N_CH-1:0] MNP,
  output logic [N_CH-1:0] MNM
);

  logic [3:0]       mcctl;
  logic             en;
  logic             centre;
  logic [1:0]       pre;
  logic [PER_W-1:0] per_sh;
  logic [PER_W-1:0] per_act;
  logic [PER_W-1:0] per_last;
  logic [PER_W-1:0] cnt;
  logic [1:0]       mode     [N_CH];
  logic [PER_W-1:0] duty_sh  [N_CH];
  logic [PER_W-1:0] duty_act [N_CH];
  logic [PER_W-1:0] thr      [N_CH];
  logic [N_CH-1:0]  sign_sh;
  logic [N_CH-1:0]  sign_act;
  logic [N_CH-1:0]  act;
  logic [2:0]       pre_cnt;
  logic [2:0]       pre_term;
  logic             tick;
  logic             dir;
  logic             loaded;
  logic             boundary;
  logic             load_now;
  logic             run;

  logic             wr_en;
  logic             idx_ok;
  logic             hit_ctl;
  logic             hit_per;
  logic             hit_cc;
  logic             hit_dc;
  logic [3:0]       idx;
  logic [15:0]      rdata;
  logic             unused_bits;

  assign en       = mcctl[0];
  assign pre      = mcctl[2:1];
  assign centre   = mcctl[3];
  assign per_last = per_act - PER_W'(1);

  // Address decode: channel registers only exist on even addresses below N_CH
  assign wr_en       = qbus.QSEL & qbus.QWRITE;
  assign idx         = qbus.QADDR[4:1];
  assign idx_ok      = ({28'd0, idx} < 32'(N_CH)) & ~qbus.QADDR[0];
  assign hit_ctl     = (qbus.QADDR == 7'h00);
  assign hit_per     = (qbus.QADDR == 7'h02);
  assign hit_cc      = (qbus.QADDR[6:5] == 2'b01) & idx_ok;
  assign hit_dc      = (qbus.QADDR[6:5] == 2'b10) & idx_ok;
  assign unused_bits = ^qbus.QDATAIN;

  // Combinational read-back of the addressed register, zero when not reading
  always_comb begin
    rdata = '0;
    if (qbus.QSEL && !qbus.QWRITE) begin
      if (hit_ctl) rdata[3:0] = mcctl;
      if (hit_per) rdata[PER_W-1:0] = per_sh;
      for (int i = 0; i < N_CH; i++) begin
        if (idx == 4'(i)) begin
          if (hit_cc) rdata[1:0] = mode[i];
          if (hit_dc) begin
            rdata[15]          = sign_sh[i];
            rdata[PER_W-1:0]   = duty_sh[i];
          end
        end
      end
    end
  end

  assign qbus.QDATAOUT = rdata;

  // Register file: control/mode act directly, period/duty land in shadows
  always_ff @(posedge QCLK or posedge QRESET) begin
    if (QRESET) begin
      mcctl   <= '0;
      per_sh  <= '0;
      sign_sh <= '0;
      for (int i = 0; i < N_CH; i++) begin
        mode[i]    <= '0;
        duty_sh[i] <= '0;
      end
    end else if (wr_en) begin
      if (hit_ctl) mcctl <= qbus.QDATAIN[3:0];
      if (hit_per) per_sh <= qbus.QDATAIN[PER_W-1:0];
      for (int i = 0; i < N_CH; i++) begin
        if (idx == 4'(i)) begin
          if (hit_cc) mode[i] <= qbus.QDATAIN[1:0];
          if (hit_dc) begin
            duty_sh[i] <= qbus.QDATAIN[PER_W-1:0];
            sign_sh[i] <= qbus.QDATAIN[15];
          end
        end
      end
    end
  end

  // Prescaler terminal count: one tick every 1/2/4/8 clocks
  always_comb begin
    case (pre)
      2'd0:    pre_term = 3'd0;
      2'd1:    pre_term = 3'd1;
      2'd2:    pre_term = 3'd3;
      default: pre_term = 3'd7;
    endcase
  end

  assign tick = en && (pre_cnt == pre_term);

  // Prescaler runs only while enabled and restarts from zero on enable
  always_ff @(posedge QCLK or posedge QRESET) begin
    if (QRESET)      pre_cnt <= '0;
    else if (!en)    pre_cnt <= '0;
    else if (tick)   pre_cnt <= '0;
    else             pre_cnt <= pre_cnt + 3'd1;
  end

  // A period ends on a wrap (edge mode) or when the down-count leaves zero (centre mode)
  assign boundary = centre ? (dir && (cnt == '0)) : (cnt >= per_last);
  assign load_now = !loaded || (per_act == '0) || boundary;

  // Period counter and active copies; shadows are sampled only at load ticks
  always_ff @(posedge QCLK or posedge QRESET) begin
    if (QRESET) begin
      cnt      <= '0;
      dir      <= 1'b0;
      loaded   <= 1'b0;
      per_act  <= '0;
      sign_act <= '0;
      for (int i = 0; i < N_CH; i++) duty_act[i] <= '0;
    end else if (!en) begin
      cnt    <= '0;
      dir    <= 1'b0;
      loaded <= 1'b0;
    end else if (tick) begin
      if (load_now) begin
        cnt      <= '0;
        dir      <= 1'b0;
        loaded   <= 1'b1;
        per_act  <= per_sh;
        sign_act <= sign_sh;
        for (int i = 0; i < N_CH; i++) duty_act[i] <= duty_sh[i];
      end else if (!centre) begin
        cnt <= cnt + PER_W'(1);
        dir <= 1'b0;
      end else if (!dir) begin
        // Top value is held for two ticks so the pulse stays symmetric
        if (cnt >= per_last) dir <= 1'b1;
        else                 cnt <= cnt + PER_W'(1);
      end else begin
        cnt <= cnt - PER_W'(1);
      end
    end
  end

  assign run = en && loaded && (per_act != '0);

  // Per-channel compare against the active duty; right-aligned threshold clamps at 0
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      thr[i] = (duty_act[i] >= per_act) ? '0 : per_act - duty_act[i];
      act[i] = 1'b0;
      case (mode[i])
        2'b01:   act[i] = (cnt < duty_act[i]);
        2'b10:   act[i] = centre ? (cnt < duty_act[i]) : (cnt >= thr[i]);
        default: act[i] = 1'b0;
      endcase
    end
  end

  // Registered pin drive; sign steers the pulse to exactly one side of the bridge
  always_ff @(posedge QCLK or posedge QRESET) begin
    if (QRESET) begin
      MNP <= '0;
      MNM <= '0;
    end else begin
      MNP <= run ? (act & ~sign_act) : '0;
      MNM <= run ? (act & sign_act) : '0;
    end
  end

endmodule

// File: tb/tb_smc_pwm_core.sv
// tb/tb_smc_pwm_core.sv - self-checking bench for smc_pwm_core
module tb_smc_pwm_core;
  localparam int N_CH  = 12;
  localparam int PER_W = 11;

  typedef struct {
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rexp;
  } reg_vec_t;

  typedef struct {
    int ch;
    int per;
    int pre;
    bit centre;
    int mode;
    int duty;
    bit sign;
    int exp_p;
    int exp_m;
  } pwm_vec_t;

  logic            QCLK;
  logic            QRESET;
  logic [N_CH-1:0] MNP;
  logic [N_CH-1:0] MNM;

  smc_pwm_core_if qbus ();

  smc_pwm_core #(.N_CH(N_CH), .PER_W(PER_W)) dut (
    .QCLK   (QCLK),
    .QRESET (QRESET),
    .qbus   (qbus),
    .MNP    (MNP),
    .MNM    (MNM)
  );

  initial QCLK = 1'b0;
  always #5 QCLK = ~QCLK;

  int checks = 0;
  int errors = 0;
  int n = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge QCLK);
    #1;
    n++;
  endtask

  task automatic bus_write(input logic [6:0] a, input logic [15:0] d);
    qbus.QSEL    = 1'b1;
    qbus.QWRITE  = 1'b1;
    qbus.QADDR   = a;
    qbus.QDATAIN = d;
    step();
    qbus.QSEL    = 1'b0;
    qbus.QWRITE  = 1'b0;
  endtask

  task automatic bus_read(input logic [6:0] a, output logic [15:0] d);
    qbus.QSEL   = 1'b1;
    qbus.QWRITE = 1'b0;
    qbus.QADDR  = a;
    @(negedge QCLK);
    d = qbus.QDATAOUT;
    qbus.QSEL   = 1'b0;
  endtask

  task automatic check_regs_zero(input string tag);
    logic [15:0] rd;
    bus_read(7'h00, rd); check({tag, "_mcctl"}, 32'(rd), 32'h0);
    bus_read(7'h02, rd); check({tag, "_mcper"}, 32'(rd), 32'h0);
    for (int i = 0; i < N_CH; i++) begin
      bus_read(7'(32'h20 + 2 * i), rd); check({tag, "_mccc"}, 32'(rd), 32'h0);
      bus_read(7'(32'h40 + 2 * i), rd); check({tag, "_mcdc"}, 32'(rd), 32'h0);
    end
  endtask

  function automatic logic [15:0] dc_word(input int duty, input bit sign);
    logic [15:0] w;
    w     = 16'(duty);
    w[15] = sign;
    return w;
  endfunction

  // Reference: where the period is at clock n after the enable edge, from tick arithmetic.
  // Returns {MNM, MNP} for one channel with constant settings.
  function automatic logic [1:0] model_pin(input int cyc, input int per, input int pre,
                                           input bit centre, input int mode, input int duty,
                                           input bit sign);
    int  d, k, len, p, c;
    bit  a;
    d = 1 << pre;
    k = (cyc - 1) / d;
    if (k == 0 || mode == 0 || mode == 3) return 2'b00;
    len = centre ? 2 * per : per;
    p   = (k - 1) % len;
    c   = (centre && p >= per) ? 2 * per - 1 - p : p;
    if (centre || mode == 1) a = (c < duty);
    else                     a = (c >= per - duty);
    return {a && sign, a && !sign};
  endfunction

  task automatic run_pwm_vec(input pwm_vec_t v, input int idx);
    int hp, hm, d, len;
    bus_write(7'h00, 16'h0000);
    bus_write(7'h02, 16'(v.per));
    bus_write(7'(32'h20 + 2 * v.ch), 16'(v.mode));
    bus_write(7'(32'h40 + 2 * v.ch), dc_word(v.duty, v.sign));
    bus_write(7'h00, {12'd0, v.centre, 2'(v.pre), 1'b1});
    n   = 0;
    d   = 1 << v.pre;
    len = v.centre ? 2 * v.per : v.per;
    repeat (2 * d + 2) step();
    hp = 0;
    hm = 0;
    repeat (len * d) begin
      step();
      hp += int'(MNP[v.ch]);
      hm += int'(MNM[v.ch]);
    end
    check($sformatf("pwm_vec%0d_mnp_high", idx), 32'(hp), 32'(v.exp_p));
    check($sformatf("pwm_vec%0d_mnm_high", idx), 32'(hm), 32'(v.exp_m));
  endtask

  initial begin
    reg_vec_t        rv [12];
    pwm_vec_t        pv [10];
    logic [15:0]     rd;
    logic [N_CH-1:0] ep, em, acc;
    logic [1:0]      pin;
    int              dq [4];
    bit              sq [4];
    int              p, q, per, pre, len, d;
    bit              centre, a;
    int              mode_r [N_CH];
    int              duty_r [N_CH];
    bit              sign_r [N_CH];

    rv[0]  = '{7'h00, 16'hFFF6, 16'h0006};
    rv[1]  = '{7'h02, 16'hFFFF, 16'h07FF};
    rv[2]  = '{7'h20, 16'hFFFF, 16'h0003};
    rv[3]  = '{7'h36, 16'h0002, 16'h0002};
    rv[4]  = '{7'h40, 16'hFFFF, 16'h87FF};
    rv[5]  = '{7'h56, 16'h1234, 16'h0234};
    rv[6]  = '{7'h58, 16'hFFFF, 16'h0000};
    rv[7]  = '{7'h38, 16'hFFFF, 16'h0000};
    rv[8]  = '{7'h7E, 16'hFFFF, 16'h0000};
    rv[9]  = '{7'h04, 16'hFFFF, 16'h0000};
    rv[10] = '{7'h41, 16'hFFFF, 16'h0000};
    rv[11] = '{7'h60, 16'hFFFF, 16'h0000};

    pv[0] = '{0, 10, 0, 1'b0, 1, 3,  1'b0, 3,  0};
    pv[1] = '{0, 10, 0, 1'b0, 1, 3,  1'b1, 0,  3};
    pv[2] = '{1, 10, 0, 1'b0, 2, 4,  1'b0, 4,  0};
    pv[3] = '{1, 10, 0, 1'b0, 2, 0,  1'b0, 0,  0};
    pv[4] = '{1, 10, 0, 1'b0, 2, 12, 1'b0, 10, 0};
    pv[5] = '{2, 8,  1, 1'b1, 1, 2,  1'b0, 8,  0};
    pv[6] = '{3, 8,  1, 1'b1, 2, 2,  1'b1, 0,  8};
    pv[7] = '{11, 5, 2, 1'b0, 1, 5,  1'b0, 20, 0};
    pv[8] = '{5, 6,  3, 1'b0, 3, 3,  1'b0, 0,  0};
    pv[9] = '{4, 1,  0, 1'b1, 1, 1,  1'b0, 2,  0};

    dq = '{3, 7, 7, 3};
    sq = '{1'b0, 1'b0, 1'b0, 1'b1};

    qbus.QSEL    = 1'b0;
    qbus.QWRITE  = 1'b0;
    qbus.QADDR   = '0;
    qbus.QDATAIN = '0;
    QRESET       = 1'b1;
    repeat (2) @(posedge QCLK);
    #1;
    QRESET = 1'b0;

    check("reset_mnp", 32'(MNP), 32'h0);
    check("reset_mnm", 32'(MNM), 32'h0);
    check_regs_zero("reset");

    for (int i = 0; i < 12; i++) begin
      bus_write(rv[i].addr, rv[i].wdata);
      bus_read(rv[i].addr, rd);
      check($sformatf("reg_vec%0d_addr%02h", i, rv[i].addr), 32'(rd), 32'(rv[i].rexp));
    end
    bus_read(7'h40, rd);
    check("reg_mcdc0_after_unmapped", 32'(rd), 32'h87FF);

    for (int i = 0; i < 10; i++) run_pwm_vec(pv[i], i);

    // Duty/sign double-buffering: mid-period write and a write on the boundary edge
    bus_write(7'h00, 16'h0000);
    bus_write(7'h02, 16'd10);
    bus_write(7'h20, 16'h0001);
    bus_write(7'h40, 16'h0003);
    bus_write(7'h00, 16'h0001);
    n = 0;
    while (n < 41) begin
      if (n == 5)       bus_write(7'h40, 16'h0007);
      else if (n == 20) bus_write(7'h40, 16'h8003);
      else              step();
      if (n == 1) begin
        a = 1'b0;
        q = 0;
      end else begin
        p = (n - 2) % 10;
        q = (n - 2) / 10;
        a = (p < dq[q]);
      end
      check($sformatf("dbuf_mnp_c%0d", n), 32'(MNP[0]), 32'(a && !sq[q]));
      check($sformatf("dbuf_mnm_c%0d", n), 32'(MNM[0]), 32'(a && sq[q]));
    end

    // Disable keeps registers, drops outputs one clock later
    bus_write(7'h00, 16'h0000);
    bus_write(7'h40, 16'd12);
    bus_write(7'h00, 16'h0001);
    repeat (4) step();
    check("en_on_full_duty", 32'(MNP[0]), 32'h1);
    bus_write(7'h00, 16'h0000);
    step();
    check("en_off_mnp", 32'(MNP), 32'h0);
    check("en_off_mnm", 32'(MNM), 32'h0);
    bus_read(7'h02, rd); check("en_off_keep_mcper", 32'(rd), 32'd10);
    bus_read(7'h40, rd); check("en_off_keep_mcdc0", 32'(rd), 32'd12);
    bus_read(7'h20, rd); check("en_off_keep_mccc0", 32'(rd), 32'd1);
    qbus.QSEL  = 1'b0;
    qbus.QADDR = 7'h02;
    @(negedge QCLK);
    check("read_unselected", 32'(qbus.QDATAOUT), 32'h0);

    // Zero period keeps every pin low
    bus_write(7'h02, 16'd0);
    bus_write(7'h00, 16'h0001);
    acc = '0;
    repeat (30) begin
      step();
      acc = acc | MNP | MNM;
    end
    check("per_zero_outputs", 32'(acc), 32'h0);

    // Asynchronous reset in the middle of a running period
    bus_write(7'h00, 16'h0000);
    bus_write(7'h02, 16'd10);
    bus_write(7'h22, 16'h0002);
    bus_write(7'h42, 16'd12);
    bus_write(7'h00, 16'h0001);
    repeat (5) step();
    check("pre_reset_mnp1", 32'(MNP[1]), 32'h1);
    #2;
    QRESET = 1'b1;
    #1;
    check("async_reset_mnp", 32'(MNP), 32'h0);
    check("async_reset_mnm", 32'(MNM), 32'h0);
    step();
    QRESET = 1'b0;
    check_regs_zero("mid_reset");

    // Randomised configurations against the period-position reference
    for (int t = 0; t < 16; t++) begin
      bus_write(7'h00, 16'h0000);
      per    = int'($urandom_range(1, 12));
      pre    = int'($urandom_range(0, 3));
      centre = 1'($urandom_range(0, 1));
      bus_write(7'h02, 16'(per));
      for (int c = 0; c < N_CH; c++) begin
        mode_r[c] = int'($urandom_range(0, 3));
        duty_r[c] = int'($urandom_range(0, per + 1));
        sign_r[c] = 1'($urandom_range(0, 1));
        bus_write(7'(32'h20 + 2 * c), 16'(mode_r[c]));
        bus_write(7'(32'h40 + 2 * c), dc_word(duty_r[c], sign_r[c]));
      end
      bus_write(7'h00, {12'd0, centre, 2'(pre), 1'b1});
      n   = 0;
      d   = 1 << pre;
      len = centre ? 2 * per : per;
      repeat (2 * len * d + d + 4) begin
        step();
        for (int c = 0; c < N_CH; c++) begin
          pin   = model_pin(n, per, pre, centre, mode_r[c], duty_r[c], sign_r[c]);
          ep[c] = pin[0];
          em[c] = pin[1];
        end
        check($sformatf("rand%0d_mnp_c%0d", t, n), 32'(MNP), 32'(ep));
        check($sformatf("rand%0d_mnm_c%0d", t, n), 32'(MNM), 32'(em));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
